// File: rtl/ripple_carry_adder_pkg.sv
// Shared definitions for the ripple-carry adder slice.
package ripple_carry_adder_pkg;

    // Operand width used when the instantiating design does not override it.
    localparam int RCA_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the leaf cell of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// N-bit unsigned adder built as an explicit chain of full adders, with one
// output register stage: {c_out, sum} = a + b + c_in, one cycle of latency.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int N_WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_WIDTH-1:0] a,
    input  logic [N_WIDTH-1:0] b,
    input  logic               c_in,
    output logic [N_WIDTH-1:0] sum,
    output logic               c_out
);

    // Carry vector between stages; c[0] is the external carry-in and
    // c[N_WIDTH] is the carry out of the most significant bit.
    logic [N_WIDTH:0]   c;
    logic [N_WIDTH-1:0] s_p0;

    assign c[0] = c_in;

    for (genvar i = 0; i < N_WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s_p0[i]),
            .cout (c[i+1])
        );
    end

    // ---- stage p0 -> p1: output register ----
    logic [N_WIDTH-1:0] sum_p1;
    logic               c_out_p1;

    // Capture the combinational result each edge; reset forces a clean zero
    // and discards whatever was sampled on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1   <= '0;
            c_out_p1 <= 1'b0;
        end else begin
            sum_p1   <= s_p0;
            c_out_p1 <= c[N_WIDTH];
        end
    end

    assign sum   = sum_p1;
    assign c_out = c_out_p1;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed bench for ripple_carry_adder (N_WIDTH = 4).
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out;

    int checks = 0;
    int errors = 0;

    ripple_carry_adder #(.N_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] exp);
        logic [W:0] obs;
        obs = {c_out, sum};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed c_out,sum=%b_%h expected %b_%h",
                   tag, obs[W], obs[W-1:0], exp[W], exp[W-1:0]);
        end
    endtask

    // Drive a vector away from the active edge, clock it in, then sample.
    task automatic step(input logic r, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic vc);
        @(negedge clk);
        rst  = r;
        a    = va;
        b    = vb;
        c_in = vc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W:0] exp;
        int idx;

        rst = 1'b1; a = 4'hF; b = 4'hF; c_in = 1'b1;

        // Reset held for two edges with max operands on the inputs.
        step(1'b1, 4'hF, 4'hF, 1'b1);
        check("reset_edge1", 5'b0_0000);
        step(1'b1, 4'hF, 4'hF, 1'b1);
        check("reset_edge2", 5'b0_0000);

        // Latency: 3 + 4 must not show before the edge, only after it.
        @(negedge clk);
        rst = 1'b0; a = 4'd3; b = 4'd4; c_in = 1'b0;
        #1;
        check("latency_before_edge", 5'b0_0000);
        @(posedge clk);
        #1;
        check("latency_after_edge", 5'b0_0111);

        // Full carry propagation through every stage.
        step(1'b0, 4'hF, 4'h0, 1'b1);
        check("full_ripple", 5'b1_0000);

        // Max operands.
        step(1'b0, 4'hF, 4'hF, 1'b1);
        check("max_operands", 5'b1_1111);

        // All zeros.
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("all_zero", 5'b0_0000);

        // A few hand-picked vectors.
        step(1'b0, 4'h9, 4'h6, 1'b0);
        check("vec_9_6_0", 5'b0_1111);
        step(1'b0, 4'h9, 4'h6, 1'b1);
        check("vec_9_6_1", 5'b1_0000);
        step(1'b0, 4'hA, 4'h5, 1'b1);
        check("vec_A_5_1", 5'b1_0000);
        step(1'b0, 4'h8, 4'h8, 1'b0);
        check("vec_8_8_0", 5'b1_0000);

        // Exhaustive sweep with a single-edge reset injected mid-stream.
        idx = 0;
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    if (idx == 137) begin
                        step(1'b1, 4'(ia), 4'(ib), 1'(ci));
                        check("midstream_reset", 5'b0_0000);
                    end else begin
                        step(1'b0, 4'(ia), 4'(ib), 1'(ci));
                        exp = 5'(ia + ib + ci);
                        check($sformatf("sweep_%0d_%0d_%0d", ia, ib, ci), exp);
                    end
                    idx++;
                end
            end
        end

        // Reset again after the sweep clears the held result.
        step(1'b1, 4'hF, 4'hF, 1'b1);
        check("final_reset", 5'b0_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
